i2c_apb_cmd_sequencer: RTL and testbench

// - APB master that drives i2c_master_top's register port. One high-level request (slave addr, R/W, length)

---
 rtl/i2c_apb_cmd_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_i2c_apb_cmd_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_cmd_sequencer.sv
// Purpose: turns one (slave addr, R/W, length) request into the full APB register sequence for i2c_master_top.
// Latency: every APB access takes a gap, a SETUP and an ACCESS cycle (3+ cycles); done_o pulses on the return to IDLE.
// Backpressure: req_ready_o only in IDLE; wr_ready_o only in the W_TX gap; APB waits on pready_i; rd_valid_o cannot stall.
module i2c_apb_cmd_sequencer #(
  parameter logic [7:0]  PRESCALE   = 8'd4,
  parameter logic [15:0] POLL_LIMIT = 16'd1024,
  parameter logic [7:0]  CMD_GO     = 8'h60,
  parameter logic [7:0]  CMD_IDLE   = 8'h20
) (
  input  logic       pclk_i,
  input  logic       preset_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rw_i,
  input  logic [6:0] req_addr_i,
  input  logic [3:0] req_len_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       done_o,
  output logic       err_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [7:0] paddr_o,
  output logic [7:0] pwdata_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_PRE, S_W_ADDR, S_W_TX, S_W_GO, S_POLL, S_R_RX, S_W_END
  } state_e;

  // Sub-phase of the APB access owned by the current sequence step.
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] poll_q, poll_d;
  logic [15:0] poll_inc;
  logic [7:0]  tx_q, tx_d;
  logic        errf_q, errf_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_vld_q, rd_vld_d;

  // State register: reset lands in IDLE with the bus released, so an in-flight access is abandoned.
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_GAP;
      rw_q      <= 1'b0;
      addr_q    <= 7'd0;
      cnt_q     <= 4'd0;
      poll_q    <= 16'd0;
      tx_q      <= 8'd0;
      errf_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 8'd0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      tx_q      <= tx_d;
      errf_q    <= errf_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  // Next-state: step through gap/SETUP/ACCESS and advance the sequence when an access completes.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    tx_d      = tx_q;
    errf_d    = errf_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    poll_inc  = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;

    if (state_q == S_IDLE) begin
      if (req_valid_i) begin
        rw_d    = req_rw_i;
        addr_d  = req_addr_i;
        cnt_d   = req_len_i;
        poll_d  = 16'd0;
        errf_d  = 1'b0;
        phase_d = PH_GAP;
        state_d = S_W_PRE;
      end
    end else begin
      case (phase_q)
        PH_GAP: begin
          // TX bytes are pulled only in the gap, so the write data is frozen before SETUP.
          if (state_q != S_W_TX) begin
            phase_d = PH_SETUP;
          end else if (wr_valid_i) begin
            tx_d    = wr_data_i;
            phase_d = PH_SETUP;
          end
        end
        PH_SETUP: phase_d = PH_ACCESS;
        PH_ACCESS: begin
          if (pready_i) begin
            phase_d = PH_GAP;
            case (state_q)
              S_W_PRE:  state_d = S_W_ADDR;
              S_W_ADDR: state_d = rw_q ? S_W_GO : S_W_TX;
              S_W_TX: begin
                if (cnt_q == 4'd0) state_d = S_W_GO;
                else               cnt_d   = cnt_q - 4'd1;
              end
              S_W_GO:   state_d = S_POLL;
              S_POLL: begin
                if (prdata_i[0]) begin
                  state_d = rw_q ? S_R_RX : S_W_END;
                end else begin
                  poll_d = poll_inc;
                  if (poll_inc >= POLL_LIMIT) begin
                    errf_d  = 1'b1;
                    state_d = S_W_END;
                  end
                end
              end
              S_R_RX: begin
                rd_data_d = prdata_i;
                rd_vld_d  = 1'b1;
                if (cnt_q == 4'd0) state_d = S_W_END;
                else               cnt_d   = cnt_q - 4'd1;
              end
              S_W_END: begin
                done_d  = 1'b1;
                err_d   = errf_q;
                state_d = S_IDLE;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
        default: phase_d = PH_GAP;
      endcase
    end
  end

  // Outputs: APB fields decoded from the current step, forced to zero whenever psel_o is low.
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    wr_ready_o  = (state_q == S_W_TX) && (phase_q == PH_GAP);
    rd_data_o   = rd_data_q;
    rd_valid_o  = rd_vld_q;
    done_o      = done_q;
    err_o       = err_q;
    psel_o      = (state_q != S_IDLE) && (phase_q != PH_GAP);
    penable_o   = psel_o && (phase_q == PH_ACCESS);
    pwrite_o    = 1'b0;
    paddr_o     = 8'h00;
    pwdata_o    = 8'h00;
    if (psel_o) begin
      case (state_q)
        S_W_PRE:  begin pwrite_o = 1'b1; paddr_o = 8'h00; pwdata_o = PRESCALE;        end
        S_W_ADDR: begin pwrite_o = 1'b1; paddr_o = 8'h04; pwdata_o = {addr_q, rw_q}; end
        S_W_TX:   begin pwrite_o = 1'b1; paddr_o = 8'h02; pwdata_o = tx_q;           end
        S_W_GO:   begin pwrite_o = 1'b1; paddr_o = 8'h01; pwdata_o = CMD_GO;         end
        S_POLL:   paddr_o = 8'h06;
        S_R_RX:   paddr_o = 8'h05;
        S_W_END:  begin pwrite_o = 1'b1; paddr_o = 8'h01; pwdata_o = CMD_IDLE;       end
        default:  paddr_o = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_cmd_sequencer.sv
// Directed bench for i2c_apb_cmd_sequencer with a behavioural APB slave (stallable pready, status/receive model).
// Each test task drives one scenario and compares the logged APB accesses, RX bytes and done/err pulses.
// The slave model is updated on the falling clock edge; stimulus is also applied on falling edges.
module tb_i2c_apb_cmd_sequencer;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       req_valid, req_rw;
  logic [6:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       req_ready_o, wr_ready_o, rd_valid_o, done_o, err_o;
  logic [7:0] rd_data_o;
  logic       psel_o, penable_o, pwrite_o;
  logic [7:0] paddr_o, pwdata_o;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b0;

  always #5 pclk = ~pclk;

  i2c_apb_cmd_sequencer #(.POLL_LIMIT(16'd8)) dut (
    .pclk_i(pclk), .preset_n_i(preset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_rw_i(req_rw),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata), .pready_i(pready)
  );

  int checks = 0;
  int errors = 0;

  // Scenario knobs, written only by the test tasks.
  int         stall_n = 0;
  int         status_after = 1;
  logic [7:0] rx_vals [16];
  logic [7:0] tx_vals [16];

  // Slave/monitor state, written only by the monitor process.
  logic [16:0] log_q [$];
  logic [7:0]  rd_q [$];
  logic [16:0] snap = 17'h0;
  int done_n = 0, err_n = 0, ready_bad = 0, err_bad = 0, viol = 0;
  int acc_cnt = 0, poll_n = 0, rx_idx = 0;

  // APB slave + monitor: decides pready/prdata for the coming rising edge and logs completed accesses.
  always @(negedge pclk) begin
    if (!preset_n) begin
      pready  <= 1'b0;
      acc_cnt <= 0;
    end else begin
      if (psel_o && !penable_o) begin
        snap <= {pwrite_o, paddr_o, pwdata_o};
        if (pwrite_o && paddr_o == 8'h00) begin
          poll_n <= 0;
          rx_idx <= 0;
        end
      end
      if (psel_o && penable_o) begin
        if ({pwrite_o, paddr_o, pwdata_o} !== snap) viol <= viol + 1;
        if (acc_cnt >= stall_n) begin
          pready  <= 1'b1;
          acc_cnt <= 0;
          log_q.push_back({pwrite_o, paddr_o, (pwrite_o ? pwdata_o : 8'h00)});
          if (!pwrite_o && paddr_o == 8'h06) begin
            prdata <= (status_after != 0 && poll_n + 1 >= status_after) ? 8'h21 : 8'h20;
            poll_n <= poll_n + 1;
          end else if (!pwrite_o && paddr_o == 8'h05) begin
            prdata <= rx_vals[rx_idx[3:0]];
            rx_idx <= rx_idx + 1;
          end else begin
            prdata <= 8'h00;
          end
        end else begin
          pready  <= 1'b0;
          acc_cnt <= acc_cnt + 1;
        end
      end else begin
        pready <= 1'b0;
      end
      if (rd_valid_o) rd_q.push_back(rd_data_o);
      if (done_o) begin
        done_n <= done_n + 1;
        if (!req_ready_o) ready_bad <= ready_bad + 1;
        if (err_o) err_n <= err_n + 1;
      end
      if (err_o && !done_o) err_bad <= err_bad + 1;
    end
  end

  task automatic issue_req(input logic rw, input logic [6:0] a, input logic [3:0] l);
    @(negedge pclk);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_len = l;
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      repeat (gap) @(negedge pclk);
      wr_data  = tx_vals[i];
      wr_valid = 1'b1;
      guard = 0;
      while (!wr_ready_o && guard < 2000) begin
        @(negedge pclk);
        guard++;
      end
      if (guard >= 2000) begin
        checks++; errors++;
        $display("FAIL wr_ready_timeout byte %0d", i);
      end
      @(negedge pclk);
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int base = done_n;
    int k = 0;
    while (done_n == base && k < 3000) begin
      @(negedge pclk);
      k++;
    end
    checks++;
    if (done_n == base) begin
      errors++;
      $display("FAIL %s done_timeout got none exp done_o pulse", name);
    end
    repeat (3) @(negedge pclk);
  endtask

  task automatic test_reset();
    preset_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = 7'd0; req_len = 4'd0;
    wr_data = 8'd0; wr_valid = 1'b0;
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready_o); end
    checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b000) begin errors++; $display("FAIL rst_apb_ctl got %b exp 000", {psel_o, penable_o, pwrite_o}); end
    checks++; if ({paddr_o, pwdata_o} !== 16'h0000) begin errors++; $display("FAIL rst_apb_dat got %h exp 0000", {paddr_o, pwdata_o}); end
    checks++; if ({done_o, err_o, rd_valid_o, wr_ready_o} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {done_o, err_o, rd_valid_o, wr_ready_o}); end
    checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", rd_data_o); end
  endtask

  task automatic test_write2(input int stall, input string name);
    logic [16:0] exp [7] = '{17'h1_00_04, 17'h1_04_A0, 17'h1_02_A5, 17'h1_02_3C, 17'h1_01_60, 17'h0_06_00, 17'h1_01_20};
    int lb = log_q.size();
    int db = done_n, eb = err_n, vb = viol;
    stall_n = stall; status_after = 1;
    tx_vals[0] = 8'hA5; tx_vals[1] = 8'h3C;
    fork
      issue_req(1'b0, 7'h50, 4'd1);
      send_bytes(2, 0);
    join
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL %s busy_ready got %b exp 0", name, req_ready_o); end
    wait_done(name);
    checks++; if (log_q.size() - lb != 7) begin errors++; $display("FAIL %s access_count got %0d exp 7", name, log_q.size() - lb); end
    for (int i = 0; i < 7 && lb + i < log_q.size(); i++) begin
      checks++;
      if (log_q[lb + i] !== exp[i]) begin errors++; $display("FAIL %s access%0d got %h exp %h", name, i, log_q[lb + i], exp[i]); end
    end
    checks++; if (done_n - db != 1 || err_n - eb != 0) begin errors++; $display("FAIL %s done_err got %0d/%0d exp 1/0", name, done_n - db, err_n - eb); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL %s ready_with_done got %0d bad exp 0", name, ready_bad); end
    checks++; if (viol - vb != 0) begin errors++; $display("FAIL %s apb_stability got %0d changes exp 0", name, viol - vb); end
    stall_n = 0;
  endtask

  task automatic test_read3();
    logic [16:0] exp [8] = '{17'h1_00_04, 17'h1_04_A3, 17'h1_01_60, 17'h0_06_00,
                             17'h0_05_00, 17'h0_05_00, 17'h0_05_00, 17'h1_01_20};
    logic [7:0] exp_rd [3] = '{8'h11, 8'h22, 8'h33};
    int lb = log_q.size(), rb = rd_q.size(), db = done_n;
    status_after = 1;
    rx_vals[0] = 8'h11; rx_vals[1] = 8'h22; rx_vals[2] = 8'h33;
    issue_req(1'b1, 7'h51, 4'd2);
    wait_done("read3");
    checks++; if (log_q.size() - lb != 8) begin errors++; $display("FAIL read3 access_count got %0d exp 8", log_q.size() - lb); end
    for (int i = 0; i < 8 && lb + i < log_q.size(); i++) begin
      checks++;
      if (log_q[lb + i] !== exp[i]) begin errors++; $display("FAIL read3 access%0d got %h exp %h", i, log_q[lb + i], exp[i]); end
    end
    checks++; if (rd_q.size() - rb != 3) begin errors++; $display("FAIL read3 rd_count got %0d exp 3", rd_q.size() - rb); end
    for (int i = 0; i < 3 && rb + i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[rb + i] !== exp_rd[i]) begin errors++; $display("FAIL read3 rd%0d got %h exp %h", i, rd_q[rb + i], exp_rd[i]); end
    end
    checks++; if (done_n - db != 1) begin errors++; $display("FAIL read3 done_count got %0d exp 1", done_n - db); end
  endtask

  task automatic test_timeout();
    int lb = log_q.size(), rb = rd_q.size(), db = done_n, eb = err_n;
    int n;
    status_after = 0;
    issue_req(1'b1, 7'h51, 4'd0);
    wait_done("timeout");
    n = log_q.size() - lb;
    checks++; if (n != 12) begin errors++; $display("FAIL timeout access_count got %0d exp 12", n); end
    for (int i = 0; i < 12 && lb + i < log_q.size(); i++) begin
      logic [16:0] e;
      e = (i == 0) ? 17'h1_00_04 : (i == 1) ? 17'h1_04_A3 : (i == 2) ? 17'h1_01_60 :
          (i == 11) ? 17'h1_01_20 : 17'h0_06_00;
      checks++;
      if (log_q[lb + i] !== e) begin errors++; $display("FAIL timeout access%0d got %h exp %h", i, log_q[lb + i], e); end
    end
    checks++; if (done_n - db != 1 || err_n - eb != 1) begin errors++; $display("FAIL timeout done_err got %0d/%0d exp 1/1", done_n - db, err_n - eb); end
    checks++; if (err_bad != 0) begin errors++; $display("FAIL timeout err_without_done got %0d exp 0", err_bad); end
    checks++; if (rd_q.size() - rb != 0) begin errors++; $display("FAIL timeout rd_count got %0d exp 0", rd_q.size() - rb); end
    status_after = 1;
  endtask

  task automatic test_reset_mid();
    int k = 0, busy = 0;
    stall_n = 5; status_after = 1;
    issue_req(1'b0, 7'h50, 4'd1);
    wr_data = 8'h77; wr_valid = 1'b1;
    while (!(psel_o && penable_o && paddr_o == 8'h02) && k < 200) begin
      @(negedge pclk);
      k++;
    end
    checks++; if (k >= 200) begin errors++; $display("FAIL rstmid reach_tx_access got none exp access to 02"); end
    #2 preset_n = 1'b0;
    #1;
    checks++; if ({psel_o, penable_o} !== 2'b00) begin errors++; $display("FAIL rstmid apb_drop got %b exp 00", {psel_o, penable_o}); end
    wr_valid = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    stall_n = 0;
    @(negedge pclk);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid req_ready got %b exp 1", req_ready_o); end
    repeat (20) begin
      @(negedge pclk);
      if (psel_o) busy++;
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL rstmid idle_bus got %0d psel cycles exp 0", busy); end
  endtask

  task automatic test_len16();
    int lb = log_q.size(), db = done_n;
    status_after = 1;
    for (int i = 0; i < 16; i++) tx_vals[i] = 8'(i * 17);
    fork
      issue_req(1'b0, 7'h50, 4'd15);
      send_bytes(16, 20);
    join
    wait_done("len16");
    checks++; if (log_q.size() - lb != 21) begin errors++; $display("FAIL len16 access_count got %0d exp 21", log_q.size() - lb); end
    for (int i = 0; i < 21 && lb + i < log_q.size(); i++) begin
      logic [16:0] e;
      if (i == 0)       e = 17'h1_00_04;
      else if (i == 1)  e = 17'h1_04_A0;
      else if (i < 18)  e = {9'h1_02, 8'((i - 2) * 17)};
      else if (i == 18) e = 17'h1_01_60;
      else if (i == 19) e = 17'h0_06_00;
      else              e = 17'h1_01_20;
      checks++;
      if (log_q[lb + i] !== e) begin errors++; $display("FAIL len16 access%0d got %h exp %h", i, log_q[lb + i], e); end
    end
    checks++; if (done_n - db != 1) begin errors++; $display("FAIL len16 done_count got %0d exp 1", done_n - db); end
  endtask

  initial begin
    test_reset();
    test_write2(0, "write2");
    test_read3();
    test_write2(5, "stall5");
    test_timeout();
    test_reset_mid();
    test_len16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish exp finish before 1ms");
    $fatal(1);
  end

endmodule
